// File: rtl/mult_err_sweep.sv
// Error-statistics sweep engine: walks every W x W operand pair through an external
// multiplier and accumulates squared error, signed error, error count and worst case.
module mult_err_sweep #(
  parameter int W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  output logic [W-1:0]        mul_a,
  output logic [W-1:0]        mul_b,
  input  logic [2*W-1:0]      mul_p,
  output logic                busy,
  output logic                done,
  output logic [6*W-1:0]      sse,
  output logic signed [4*W:0] sum_err,
  output logic [2*W:0]        err_cnt,
  output logic [2*W-1:0]      max_abs,
  output logic [W-1:0]        worst_a,
  output logic [W-1:0]        worst_b
);

  localparam int PW = 2 * W;
  localparam logic [PW-1:0] CNT_PRELAST = {{(PW-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic              clear_s;
  logic              kill_s;
  logic [PW-1:0]     cnt_r;
  logic              op_valid_r;
  logic              s1_valid_r;
  logic              s2_valid_r;

  logic [PW-1:0]     p1_r;
  logic [PW-1:0]     x1_r;
  logic [W-1:0]      a1_r;
  logic [W-1:0]      b1_r;
  logic [PW:0]       e2_r;
  logic [PW-1:0]     abs2_r;
  logic [W-1:0]      a2_r;
  logic [W-1:0]      b2_r;

  logic [PW-1:0]     exact_s;
  logic [PW:0]       diff_s;
  logic [PW-1:0]     abs_s;
  logic [2*PW-1:0]   sq_s;

  assign mul_a   = cnt_r[PW-1:W];
  assign mul_b   = cnt_r[W-1:0];
  assign exact_s = {{W{1'b0}}, mul_a} * {{W{1'b0}}, mul_b};
  assign diff_s  = {1'b0, p1_r} - {1'b0, x1_r};
  assign abs_s   = diff_s[PW] ? (x1_r - p1_r) : (p1_r - x1_r);
  assign sq_s    = {{PW{1'b0}}, abs2_r} * {{PW{1'b0}}, abs2_r};

  // Next-state decode; the last pair has left S2 once S1 is empty during DRAIN.
  always_comb begin
    state_s = state_r;
    clear_s = 1'b0;
    kill_s  = 1'b0;
    case (state_r)
      IDLE, DONE: begin
        if (start) begin
          state_s = RUN;
          clear_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      RUN: begin
        if (abort) begin
          state_s = IDLE;
          kill_s  = 1'b1;
        end else if (cnt_r == CNT_PRELAST) begin
          state_s = DRAIN;
        end else begin
          state_s = RUN;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_s = IDLE;
          kill_s  = 1'b1;
        end else if (s2_valid_r && !s1_valid_r) begin
          state_s = DONE;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, operand counter, stage valid bits and status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= {PW{1'b0}};
      op_valid_r <= 1'b0;
      s1_valid_r <= 1'b0;
      s2_valid_r <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_r    <= state_s;
      busy       <= (state_s == RUN) || (state_s == DRAIN);
      done       <= (state_s == DONE);
      op_valid_r <= clear_s || ((state_r == RUN) && !kill_s);
      if (kill_s || clear_s) begin
        cnt_r      <= {PW{1'b0}};
        s1_valid_r <= 1'b0;
        s2_valid_r <= 1'b0;
      end else begin
        if (state_r == RUN) begin
          cnt_r <= cnt_r + {{(PW-1){1'b0}}, 1'b1};
        end
        s1_valid_r <= op_valid_r;
        s2_valid_r <= s1_valid_r;
      end
    end
  end

  // Capture, difference and accumulation stages; strict '>' keeps the earliest worst pair.
  always_ff @(posedge clk) begin
    if (rst || kill_s || clear_s) begin
      p1_r    <= {PW{1'b0}};
      x1_r    <= {PW{1'b0}};
      a1_r    <= {W{1'b0}};
      b1_r    <= {W{1'b0}};
      e2_r    <= {(PW+1){1'b0}};
      abs2_r  <= {PW{1'b0}};
      a2_r    <= {W{1'b0}};
      b2_r    <= {W{1'b0}};
      sse     <= {(6*W){1'b0}};
      sum_err <= {(4*W+1){1'b0}};
      err_cnt <= {(PW+1){1'b0}};
      max_abs <= {PW{1'b0}};
      worst_a <= {W{1'b0}};
      worst_b <= {W{1'b0}};
    end else begin
      p1_r   <= mul_p;
      x1_r   <= exact_s;
      a1_r   <= mul_a;
      b1_r   <= mul_b;
      e2_r   <= diff_s;
      abs2_r <= abs_s;
      a2_r   <= a1_r;
      b2_r   <= b1_r;
      if (s2_valid_r) begin
        sse     <= sse + {{(6*W-2*PW){1'b0}}, sq_s};
        sum_err <= sum_err + $signed({{(4*W-PW){e2_r[PW]}}, e2_r});
        err_cnt <= err_cnt + {{PW{1'b0}}, (|e2_r)};
        if (abs2_r > max_abs) begin
          max_abs <= abs2_r;
          worst_a <= a2_r;
          worst_b <= b2_r;
        end
      end
    end
  end

endmodule
